// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: single-entry dispatch stage between the IQ and the ALU RS / LSB.
// Holds one instruction, allocates a ROB tag and forwards it when the ROB and the
// target unit both have credits. Flush or rst returns everything to the empty state.
// Optional feature macro: DISPATCH_PERF_EN (adds perf_disp / perf_stall counters).
module dispatch_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int ALU_RS_DEPTH = 8,
  parameter int LSB_DEPTH    = 8,
  parameter int LSB_OP_BASE  = 20,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imm,
  input  logic             in_has_imm,
  output logic             iq_stall,
  input  logic             rob_free,
  input  logic             alu_free,
  input  logic             lsb_free,
  input  logic             flush,
  output logic             alu_valid,
  output logic             lsb_valid,
  output logic [4:0]       d_op,
  output logic [4:0]       d_rs1,
  output logic [4:0]       d_rs2,
  output logic [4:0]       d_rd,
  output logic [31:0]      d_imm,
  output logic             d_has_imm,
  output logic [TAG_W-1:0] d_rob_tag,
  output logic             busy
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]      perf_disp,
  output logic [31:0]      perf_stall
`endif
);

  localparam int ROB_CW = $clog2(ROB_DEPTH + 1);
  localparam int ALU_CW = $clog2(ALU_RS_DEPTH + 1);
  localparam int LSB_CW = $clog2(LSB_DEPTH + 1);
  localparam logic [ROB_CW-1:0] ROB_MAX  = ROB_CW'(ROB_DEPTH);
  localparam logic [ALU_CW-1:0] ALU_MAX  = ALU_CW'(ALU_RS_DEPTH);
  localparam logic [LSB_CW-1:0] LSB_MAX  = LSB_CW'(LSB_DEPTH);
  localparam logic [TAG_W-1:0]  TAG_LAST = TAG_W'(ROB_DEPTH - 1);
  localparam logic [4:0]        LSB_BASE = 5'(LSB_OP_BASE);
  localparam logic [4:0]        OP_BUBBLE = 5'h1f;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            r_state;
  logic [4:0]        r_h_op, r_h_rs1, r_h_rs2, r_h_rd;
  logic [31:0]       r_h_imm;
  logic              r_h_has_imm;
  logic [TAG_W-1:0]  r_tag;
  logic [ROB_CW-1:0] r_rob_cred;
  logic [ALU_CW-1:0] r_alu_cred;
  logic [LSB_CW-1:0] r_lsb_cred;

  logic w_hold, w_to_lsb, w_tgt_ok, w_fire, w_stall, w_accept;
  logic w_alu_use, w_lsb_use;

  assign w_hold    = (r_state == HOLD);
  assign w_to_lsb  = (r_h_op >= LSB_BASE);
  assign w_tgt_ok  = w_to_lsb ? (r_lsb_cred != '0) : (r_alu_cred != '0);
  assign w_fire    = w_hold && (r_rob_cred != '0) && w_tgt_ok && !flush;
  // A flush cycle never stalls the IQ: the hold is about to be discarded anyway.
  assign w_stall   = w_hold && !w_fire && !flush;
  assign w_accept  = in_valid && (in_op != OP_BUBBLE) && !w_stall && !flush;
  assign w_alu_use = w_fire && !w_to_lsb;
  assign w_lsb_use = w_fire && w_to_lsb;

  assign iq_stall = w_stall;
  assign busy     = w_hold;

  // Hold-register FSM with registered dispatch strobes, payload and tag allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_h_op      <= OP_BUBBLE;
      r_h_rs1     <= '0;
      r_h_rs2     <= '0;
      r_h_rd      <= '0;
      r_h_imm     <= '0;
      r_h_has_imm <= 1'b0;
      r_tag       <= '0;
      alu_valid   <= 1'b0;
      lsb_valid   <= 1'b0;
      d_op        <= OP_BUBBLE;
      d_rs1       <= '0;
      d_rs2       <= '0;
      d_rd        <= '0;
      d_imm       <= '0;
      d_has_imm   <= 1'b0;
      d_rob_tag   <= '0;
    end else if (flush) begin
      // d_* keep their last value; only the strobes and tag allocator clear.
      r_state   <= IDLE;
      r_tag     <= '0;
      alu_valid <= 1'b0;
      lsb_valid <= 1'b0;
    end else begin
      alu_valid <= w_alu_use;
      lsb_valid <= w_lsb_use;
      if (w_fire) begin
        d_op      <= r_h_op;
        d_rs1     <= r_h_rs1;
        d_rs2     <= r_h_rs2;
        d_rd      <= r_h_rd;
        d_imm     <= r_h_imm;
        d_has_imm <= r_h_has_imm;
        d_rob_tag <= r_tag;
        r_tag     <= (r_tag == TAG_LAST) ? '0 : r_tag + 1'b1;
      end
      // Accept in a fire cycle refills the hold, sustaining one instr per cycle.
      if (w_accept) begin
        r_state     <= HOLD;
        r_h_op      <= in_op;
        r_h_rs1     <= in_rs1;
        r_h_rs2     <= in_rs2;
        r_h_rd      <= in_rd;
        r_h_imm     <= in_imm;
        r_h_has_imm <= in_has_imm;
      end else if (w_fire) begin
        r_state <= IDLE;
      end
    end
  end

  // ROB credits: a free and a consume in the same cycle cancel; frees saturate at max.
  always_ff @(posedge clk) begin
    if (rst || flush)                                     r_rob_cred <= ROB_MAX;
    else if (rob_free && !w_fire && r_rob_cred != ROB_MAX) r_rob_cred <= r_rob_cred + 1'b1;
    else if (w_fire && !rob_free)                          r_rob_cred <= r_rob_cred - 1'b1;
  end

  // ALU RS credits, same rules as ROB credits.
  always_ff @(posedge clk) begin
    if (rst || flush)                                          r_alu_cred <= ALU_MAX;
    else if (alu_free && !w_alu_use && r_alu_cred != ALU_MAX)  r_alu_cred <= r_alu_cred + 1'b1;
    else if (w_alu_use && !alu_free)                           r_alu_cred <= r_alu_cred - 1'b1;
  end

  // LSB credits, same rules as ROB credits.
  always_ff @(posedge clk) begin
    if (rst || flush)                                          r_lsb_cred <= LSB_MAX;
    else if (lsb_free && !w_lsb_use && r_lsb_cred != LSB_MAX)  r_lsb_cred <= r_lsb_cred + 1'b1;
    else if (w_lsb_use && !lsb_free)                           r_lsb_cred <= r_lsb_cred - 1'b1;
  end

`ifdef DISPATCH_PERF_EN
  // Performance counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_disp  <= '0;
      perf_stall <= '0;
    end else begin
      if (w_fire)  perf_disp  <= perf_disp + 32'd1;
      if (w_stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed scenarios plus random traffic against a queue/integer
// reference model of the dispatch stage.
module tb_dispatch_ctrl;
  localparam int ROB = 16, ALUD = 8, LSBD = 8, LBASE = 20, TW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_has_imm, rob_free, alu_free, lsb_free, flush;
  logic [4:0] in_op, in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic iq_stall, alu_valid, lsb_valid, d_has_imm, busy;
  logic [4:0] d_op, d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic [TW-1:0] d_rob_tag;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp, perf_stall;
`endif

  always #5 clk = ~clk;

  dispatch_ctrl #(.ROB_DEPTH(ROB), .ALU_RS_DEPTH(ALUD), .LSB_DEPTH(LSBD),
                  .LSB_OP_BASE(LBASE), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_has_imm(in_has_imm),
    .iq_stall(iq_stall), .rob_free(rob_free), .alu_free(alu_free), .lsb_free(lsb_free),
    .flush(flush), .alu_valid(alu_valid), .lsb_valid(lsb_valid), .d_op(d_op),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_imm(d_imm), .d_has_imm(d_has_imm),
    .d_rob_tag(d_rob_tag), .busy(busy)
`ifdef DISPATCH_PERF_EN
    , .perf_disp(perf_disp), .perf_stall(perf_stall)
`endif
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: the hold register is a queue of at most one instruction,
  // credits are plain integers.
  typedef struct packed {
    logic [4:0] op, rs1, rs2, rd;
    logic [31:0] imm;
    logic hi;
  } ins_t;

  ins_t hq[$];
  ins_t e_d;
  int rob_c, alu_c, lsb_c, tag, e_tag;
  bit e_alu, e_lsb, m_acc, chk_comb;
  logic [31:0] p_disp, p_stall;

  function automatic int cred(input int c, input bit free, input bit use_, input int mx);
    int n;
    n = c - int'(use_) + int'(free);
    return (n > mx) ? mx : n;
  endfunction

  task automatic reset_model();
    hq.delete();
    e_alu = 0; e_lsb = 0;
    e_d = '0; e_d.op = 5'd31;
    e_tag = 0; tag = 0;
    rob_c = ROB; alu_c = ALUD; lsb_c = LSBD;
  endtask

  task automatic tick();
    bit alu_t, fire, stall;
    ins_t cur;
    alu_t = 0; fire = 0;
    @(negedge clk);
    if (hq.size() > 0) begin
      alu_t = hq[0].op < LBASE;
      fire  = !flush && rob_c > 0 && (alu_t ? alu_c > 0 : lsb_c > 0);
    end
    stall = hq.size() > 0 && !fire && !flush;
    if (chk_comb) begin
      chk("iq_stall", iq_stall, stall);
      chk("busy", busy, hq.size() > 0);
    end
    cur = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm, hi: in_has_imm};
    @(posedge clk);
    m_acc = 0;
    if (rst) begin
      reset_model();
      p_disp = 0; p_stall = 0;
    end else begin
      p_disp  += 32'(fire);
      p_stall += 32'(stall);
      if (flush) begin
        hq.delete();
        e_alu = 0; e_lsb = 0; tag = 0;
        rob_c = ROB; alu_c = ALUD; lsb_c = LSBD;
      end else begin
        e_alu = fire && alu_t;
        e_lsb = fire && !alu_t;
        if (fire) begin
          e_d = hq.pop_front();
          e_tag = tag;
          tag = (tag + 1) % ROB;
        end
        rob_c = cred(rob_c, rob_free, fire, ROB);
        alu_c = cred(alu_c, alu_free, fire && alu_t, ALUD);
        lsb_c = cred(lsb_c, lsb_free, fire && !alu_t, LSBD);
        if (in_valid && in_op != 5'd31 && !stall) begin
          hq.push_back(cur);
          m_acc = 1;
        end
      end
    end
    #1;
    chk("alu_valid", alu_valid, e_alu);
    chk("lsb_valid", lsb_valid, e_lsb);
    chk("d_payload", {d_op, d_rs1, d_rs2, d_rd, d_imm, d_has_imm}, e_d);
    chk("d_rob_tag", d_rob_tag, e_tag);
`ifdef DISPATCH_PERF_EN
    chk("perf_disp", perf_disp, p_disp);
    chk("perf_stall", perf_stall, p_stall);
`endif
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 5'd31; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_imm = 0; in_has_imm = 0; rob_free = 0; alu_free = 0; lsb_free = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  int n_alu_d, n_lsb_d, idx;
  logic [15:0] seen;

  initial begin
    reset_model();
    p_disp = 0; p_stall = 0;
    chk_comb = 0;
    idle_inputs();
    rst = 1;
    tick();
    chk_comb = 1;
    tick();
    rst = 0;
    chk("rst_d_op", d_op, 5'd31);
    chk("rst_strobes", {alu_valid, lsb_valid}, 2'b00);
    chk("rst_busy", busy, 1'b0);

    // 1: single ALU op
    in_valid = 1; in_op = 5'd3; in_rd = 5'd5; tick();
    idle_inputs(); tick();
    chk("t1_alu", alu_valid, 1'b1);
    chk("t1_tag", d_rob_tag, 4'd0);
    chk("t1_rd", d_rd, 5'd5);
    tick();
    chk("t1_alu_1cyc", alu_valid, 1'b0);
    chk("t1_lsb", lsb_valid, 1'b0);

    // 2: 20 alternating ALU/LSB ops with no frees
    do_reset();
    n_alu_d = 0; n_lsb_d = 0; idx = 0; seen = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 20);
      in_op = (idx % 2 == 1) ? 5'(LBASE + idx % 11) : 5'(idx % 20);
      in_rd = 5'(idx); in_imm = $urandom; in_has_imm = idx[0];
      tick();
      if (m_acc) idx++;
      if (alu_valid) n_alu_d++;
      if (lsb_valid) n_lsb_d++;
      if (alu_valid || lsb_valid) seen[d_rob_tag] = 1'b1;
    end
    chk("t2_alu_cnt", n_alu_d, 8);
    chk("t2_lsb_cnt", n_lsb_d, 8);
    chk("t2_tags", seen, 16'hffff);
    chk("t2_stall", iq_stall, 1'b1);

    // 3: ROB+ALU free with ALU op held -> one dispatch with wrapped tag
    rob_free = 1; alu_free = 1; tick();
    rob_free = 0; alu_free = 0;
    in_op = 5'(LBASE + 17 % 11); in_rd = 5'd17; tick();
    chk("t3_alu", alu_valid, 1'b1);
    chk("t3_tag", d_rob_tag, 4'd0);
    chk("t3_acc", m_acc, 1'b1);
    idle_inputs(); tick();
    chk("t3_stall", iq_stall, 1'b1);

    // 4: LSB op held with no LSB credit, then lsb_free
    rob_free = 1; tick(); rob_free = 0;
    lsb_free = 1; tick(); lsb_free = 0;
    chk("t4_lsb_early", lsb_valid, 1'b0);
    tick();
    chk("t4_lsb", lsb_valid, 1'b1);
    chk("t4_tag", d_rob_tag, 4'd1);

    // 5: flush with strobe pending
    do_reset();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_op = 5'(k + 1); tick();
    end
    in_op = 5'd9; tick();
    idle_inputs(); flush = 1; tick(); flush = 0;
    chk("t5_strobe", alu_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    in_valid = 1; in_op = 5'd7; tick();
    idle_inputs(); tick();
    chk("t5_alu", alu_valid, 1'b1);
    chk("t5_tag", d_rob_tag, 4'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_op = 5'($urandom_range(0, 31));
      in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
      in_imm = $urandom; in_has_imm = 1'($urandom);
      rob_free = ($urandom_range(0, 3) == 0);
      alu_free = ($urandom_range(0, 3) == 0);
      lsb_free = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0; idle_inputs(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
